// File: rtl/axi_router_pkg.sv
// Shared definitions for the AXI response router: slave address map,
// FSM state encodings and AXI response codes.
package axi_router_pkg;

    // Largest number of decoded slaves the map tables can describe.
    localparam int NUM_S_MAX = 15;

    // Width of the entries in the address map tables.
    localparam int MAP_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Slave windows: a slave claims an address when (addr & MASK) == BASE.
    // Slaves 4 and 5 overlap on 0x40xx_xxxx; the lower index takes it.
    // 0xFxxx_xxxx is never claimed and always falls to the default slave.
    localparam logic [MAP_W-1:0] SLAVE_BASE [NUM_S_MAX] = '{
        32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
        32'h4000_0000, 32'h4000_0000, 32'h6000_0000, 32'h7000_0000,
        32'h8000_0000, 32'h9000_0000, 32'hA000_0000, 32'hB000_0000,
        32'hC000_0000, 32'hD000_0000, 32'hE000_0000
    };

    localparam logic [MAP_W-1:0] SLAVE_MASK [NUM_S_MAX] = '{
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000,
        32'hF000_0000, 32'hF000_0000, 32'hF000_0000
    };

    // Read FSM encodings.
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;
    localparam logic [1:0] R_DS   = 2'd3;

    // Write FSM encodings.
    localparam logic [2:0] W_IDLE    = 3'd0;
    localparam logic [2:0] W_ADDR    = 3'd1;
    localparam logic [2:0] W_DATA    = 3'd2;
    localparam logic [2:0] W_RESP    = 3'd3;
    localparam logic [2:0] W_DS_DATA = 3'd4;
    localparam logic [2:0] W_DS_RESP = 3'd5;

    // True when slave idx's window claims the address.
    function automatic logic addr_match(input logic [MAP_W-1:0] addr, input int idx);
        return (addr & SLAVE_MASK[idx]) == SLAVE_BASE[idx];
    endfunction

endpackage

// File: rtl/axi_addr_decoder.sv
// Address decoder: maps an address onto a one-hot slave select using the
// shared address map. No hit means the default slave owns the access.
module axi_addr_decoder
    import axi_router_pkg::*;
#(
    parameter int NUM_S  = 6,
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NUM_S-1:0]  sel_o,
    output logic              hit_o
);

    logic [MAP_W-1:0] addr_map;

    assign addr_map = MAP_W'(addr_i);

    // Priority match: the lowest-index window that claims the address wins.
    always_comb begin
        // NOTE: every output is given a default before any branch, so no path leaves it unassigned and no latch is inferred.
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (!hit_o && addr_match(addr_map, i)) begin
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_resp_router.sv
// AXI response router: decodes AR/AW addresses onto NUM_S slaves, drives the
// one-hot selects for the master-to-slave mux, mirrors the selected slave's
// R/B channels back to the master, and answers unmapped accesses with DECERR.
module axi_resp_router
    import axi_router_pkg::*;
#(
    parameter int NUM_S  = 6,
    parameter int ID_W   = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_W-1:0]       ARADDR,
    input  logic [ID_W-1:0]         ARID,
    input  logic [7:0]              ARLEN,
    input  logic                    ARVALID,
    input  logic [ADDR_W-1:0]       AWADDR,
    input  logic [ID_W-1:0]         AWID,
    input  logic                    AWVALID,
    input  logic                    WVALID,
    input  logic                    WLAST,
    input  logic                    RREADY,
    input  logic                    BREADY,
    input  logic [NUM_S*ID_W-1:0]   RID_S,
    input  logic [NUM_S*DATA_W-1:0] RDATA_S,
    input  logic [NUM_S*2-1:0]      RRESP_S,
    input  logic [NUM_S-1:0]        RLAST_S,
    input  logic [NUM_S-1:0]        RVALID_S,
    input  logic [NUM_S*ID_W-1:0]   BID_S,
    input  logic [NUM_S*2-1:0]      BRESP_S,
    input  logic [NUM_S-1:0]        BVALID_S,
    input  logic [NUM_S-1:0]        ARREADY_S,
    input  logic [NUM_S-1:0]        AWREADY_S,
    input  logic [NUM_S-1:0]        WREADY_S,
    output logic [ID_W-1:0]         RID,
    output logic [DATA_W-1:0]       RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    output logic [ID_W-1:0]         BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    output logic                    ARREADY,
    output logic                    AWREADY,
    output logic                    WREADY,
    output logic [NUM_S-1:0]        AR_SEL,
    output logic [NUM_S-1:0]        AW_SEL,
    output logic [NUM_S-1:0]        W_SEL
);

    // Decoded address phases
    logic [NUM_S-1:0] ar_dec_sel;
    logic             ar_dec_hit;
    logic [NUM_S-1:0] aw_dec_sel;
    logic             aw_dec_hit;

    // Read channel state
    logic [1:0]       r_state_q,  r_state_d;
    logic [NUM_S-1:0] ar_tgt_q,   ar_tgt_d;
    logic             ar_ds_q,    ar_ds_d;
    logic [ID_W-1:0]  arid_q,     arid_d;
    logic [7:0]       arlen_q,    arlen_d;
    logic [7:0]       r_cnt_q,    r_cnt_d;

    // Write channel state
    logic [2:0]       w_state_q,  w_state_d;
    logic [NUM_S-1:0] aw_tgt_q,   aw_tgt_d;
    logic             aw_ds_q,    aw_ds_d;
    logic [ID_W-1:0]  awid_q,     awid_d;

    axi_addr_decoder #(
        .NUM_S  (NUM_S),
        .ADDR_W (ADDR_W)
    ) u_ar_dec (
        .addr_i (ARADDR),
        .sel_o  (ar_dec_sel),
        .hit_o  (ar_dec_hit)
    );

    axi_addr_decoder #(
        .NUM_S  (NUM_S),
        .ADDR_W (ADDR_W)
    ) u_aw_dec (
        .addr_i (AWADDR),
        .sel_o  (aw_dec_sel),
        .hit_o  (aw_dec_hit)
    );

    // Read FSM next state: capture target/ID/length in idle, then sequence the burst.
    always_comb begin
        r_state_d = r_state_q;
        ar_tgt_d  = ar_tgt_q;
        ar_ds_d   = ar_ds_q;
        arid_d    = arid_q;
        arlen_d   = arlen_q;
        r_cnt_d   = r_cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    r_state_d = R_ADDR;
                    ar_tgt_d  = ar_dec_sel;
                    ar_ds_d   = !ar_dec_hit;
                    arid_d    = ARID;
                    arlen_d   = ARLEN;
                    r_cnt_d   = '0;
                end
            end
            R_ADDR: begin
                if (ARVALID && ARREADY) begin
                    r_state_d = ar_ds_q ? R_DS : R_DATA;
                end
            end
            R_DATA: begin
                if (RVALID && RREADY && RLAST) begin
                    r_state_d = R_IDLE;
                end
            end
            R_DS: begin
                // Counter runs 0..ARLEN and is compared, never wrapped, so ARLEN=255 gives 256 beats.
                if (RREADY) begin
                    if (r_cnt_q == arlen_q) begin
                        r_state_d = R_IDLE;
                        r_cnt_d   = '0;
                    end else begin
                        r_cnt_d = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs: selects/ready in address phase, mirrored or DECERR beats in data phase.
    always_comb begin
        AR_SEL  = '0;
        ARREADY = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = '0;
        RLAST   = 1'b0;
        RVALID  = 1'b0;
        case (r_state_q)
            R_ADDR: begin
                AR_SEL  = ar_tgt_q;
                ARREADY = ar_ds_q ? 1'b1 : |(ARREADY_S & ar_tgt_q);
            end
            R_DATA: begin
                for (int i = 0; i < NUM_S; i++) begin
                    if (ar_tgt_q[i]) begin
                        RID    = RID_S[i*ID_W +: ID_W];
                        RDATA  = RDATA_S[i*DATA_W +: DATA_W];
                        RRESP  = RRESP_S[i*2 +: 2];
                        RLAST  = RLAST_S[i];
                        RVALID = RVALID_S[i];
                    end
                end
            end
            R_DS: begin
                RVALID = 1'b1;
                RRESP  = RESP_DECERR;
                RID    = arid_q;
                RLAST  = (r_cnt_q == arlen_q);
            end
            default: ;
        endcase
    end

    // Write FSM next state: capture target/ID in idle, then address, data, response.
    always_comb begin
        w_state_d = w_state_q;
        aw_tgt_d  = aw_tgt_q;
        aw_ds_d   = aw_ds_q;
        awid_d    = awid_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    w_state_d = W_ADDR;
                    aw_tgt_d  = aw_dec_sel;
                    aw_ds_d   = !aw_dec_hit;
                    awid_d    = AWID;
                end
            end
            W_ADDR: begin
                if (AWVALID && AWREADY) begin
                    w_state_d = aw_ds_q ? W_DS_DATA : W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && WREADY && WLAST) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BVALID && BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            W_DS_DATA: begin
                if (WVALID && WLAST) begin
                    w_state_d = W_DS_RESP;
                end
            end
            W_DS_RESP: begin
                if (BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs: selects/readies per phase, mirrored or DECERR write response.
    always_comb begin
        AW_SEL  = '0;
        AWREADY = 1'b0;
        W_SEL   = '0;
        WREADY  = 1'b0;
        BID     = '0;
        BRESP   = '0;
        BVALID  = 1'b0;
        case (w_state_q)
            W_ADDR: begin
                AW_SEL  = aw_tgt_q;
                AWREADY = aw_ds_q ? 1'b1 : |(AWREADY_S & aw_tgt_q);
            end
            W_DATA: begin
                W_SEL  = aw_tgt_q;
                WREADY = |(WREADY_S & aw_tgt_q);
            end
            W_RESP: begin
                for (int i = 0; i < NUM_S; i++) begin
                    if (aw_tgt_q[i]) begin
                        BID    = BID_S[i*ID_W +: ID_W];
                        BRESP  = BRESP_S[i*2 +: 2];
                        BVALID = BVALID_S[i];
                    end
                end
            end
            W_DS_DATA: begin
                WREADY = 1'b1;
            end
            W_DS_RESP: begin
                BVALID = 1'b1;
                BRESP  = RESP_DECERR;
                BID    = awid_q;
            end
            default: ;
        endcase
    end

    // State registers for both channels; reset abandons any burst in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            ar_tgt_q  <= '0;
            ar_ds_q   <= 1'b0;
            arid_q    <= '0;
            arlen_q   <= '0;
            r_cnt_q   <= '0;
            w_state_q <= W_IDLE;
            aw_tgt_q  <= '0;
            aw_ds_q   <= 1'b0;
            awid_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            r_state_q <= r_state_d;
            ar_tgt_q  <= ar_tgt_d;
            ar_ds_q   <= ar_ds_d;
            arid_q    <= arid_d;
            arlen_q   <= arlen_d;
            r_cnt_q   <= r_cnt_d;
            w_state_q <= w_state_d;
            aw_tgt_q  <= aw_tgt_d;
            aw_ds_q   <= aw_ds_d;
            awid_q    <= awid_d;
        end
    end

endmodule
